// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the popcount accumulator slice.
package popcount_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  localparam int unsigned COMP_IN_W  = 7;
  localparam int unsigned COMP_OUT_W = 3;

  // Smallest width that holds 7*frame_len, the largest possible frame total.
  function automatic int unsigned sum_width(input int unsigned frame_len);
    return unsigned'($clog2(7 * frame_len + 1));
  endfunction

endpackage

// File: rtl/popcount_accum_comp73.sv
// Comp73 compressor: 7 input bits reduced to their 3-bit ones-count by a full-adder tree.
module comp73
  import popcount_pkg::*;
(
  input  logic [COMP_IN_W-1:0]  din,
  output logic [COMP_OUT_W-1:0] cnt
);

  logic s_a, c_a, s_b, c_b, s_c, c_c, s_d, c_d;

  always_comb begin
    // Two weight-1 full adders, then merge their sums with bit 6.
    s_a = din[0] ^ din[1] ^ din[2];
    c_a = (din[0] & din[1]) | (din[0] & din[2]) | (din[1] & din[2]);
    s_b = din[3] ^ din[4] ^ din[5];
    c_b = (din[3] & din[4]) | (din[3] & din[5]) | (din[4] & din[5]);
    s_c = s_a ^ s_b ^ din[6];
    c_c = (s_a & s_b) | (s_a & din[6]) | (s_b & din[6]);
    // Three weight-2 carries compress into the upper two count bits.
    s_d = c_a ^ c_b ^ c_c;
    c_d = (c_a & c_b) | (c_a & c_c) | (c_b & c_c);
    cnt = {c_d, s_d, s_c};
  end

endmodule

// File: rtl/popcount_accum.sv
// Frame-based popcount accumulator: sums Comp73 counts over up to FRAME_LEN words
// and presents the total on a valid/ready output.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter  int unsigned FRAME_LEN = 16,
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1),
  localparam int unsigned SUM_W     = sum_width(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_words
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state, state_d;
  logic [SUM_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] word_cnt, word_cnt_d;
  logic             out_valid_d;
  logic [SUM_W-1:0] out_sum_d;
  logic [CNT_W-1:0] out_words_d;

  logic [2:0]       cnt3;
  logic [SUM_W-1:0] nxt;
  logic [CNT_W-1:0] wnxt;
  logic             accept;
  logic             drain;
  logic             end_of_frame;

  comp73 u_comp73 (
    .din (in_data),
    .cnt (cnt3)
  );

  // Gating with rst_n keeps the input stalled for the whole reset window.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (state == S_OUT) in_ready = out_ready & ~flush;
      else                in_ready = ~flush;
    end
  end

  always_comb begin
    accept       = in_valid & in_ready;
    drain        = out_valid & out_ready;
    nxt          = acc + SUM_W'(cnt3);
    wnxt         = word_cnt + CNT_W'(1);
    end_of_frame = accept & (in_last | (word_cnt == LAST_IDX));
  end

  always_comb begin
    state_d     = state;
    acc_d       = acc;
    word_cnt_d  = word_cnt;
    out_valid_d = out_valid;
    out_sum_d   = out_sum;
    out_words_d = out_words;

    if (flush) begin
      acc_d      = '0;
      word_cnt_d = '0;
    end

    unique case (state)
      S_IDLE, S_ACC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (end_of_frame) begin
          out_sum_d   = nxt;
          out_words_d = wnxt;
          out_valid_d = 1'b1;
          acc_d       = '0;
          word_cnt_d  = '0;
          state_d     = S_OUT;
        end else if (accept) begin
          acc_d      = nxt;
          word_cnt_d = wnxt;
          state_d    = S_ACC;
        end
      end
      S_OUT: begin
        // Any accept here implies out_ready, so the held result drains this cycle.
        if (end_of_frame) begin
          out_sum_d   = nxt;
          out_words_d = wnxt;
          out_valid_d = 1'b1;
          acc_d       = '0;
          word_cnt_d  = '0;
          state_d     = S_OUT;
        end else if (accept) begin
          acc_d       = nxt;
          word_cnt_d  = wnxt;
          out_valid_d = 1'b0;
          state_d     = S_ACC;
        end else if (drain) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = '0;
        word_cnt_d  = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_words <= '0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      word_cnt  <= word_cnt_d;
      out_valid <= out_valid_d;
      out_sum   <= out_sum_d;
      out_words <= out_words_d;
    end
  end

endmodule
